// File: rtl/traffic_pkg.sv
// Shared definitions for the two-road traffic-light controller:
// light encodings and the phase state enumeration.
package traffic_pkg;

  localparam logic [1:0] LIGHT_GREEN  = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_RED    = 2'b10;

  typedef enum logic [1:0] {
    S_AG = 2'd0,
    S_AY = 2'd1,
    S_BG = 2'd2,
    S_BY = 2'd3
  } state_t;

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Signal bundle between the traffic-light controller and its environment:
// tick and vehicle sensors in, light drives and phase code out.
interface traffic_light_ctrl_if;

  logic       tick;
  logic       ta;
  logic       tb;
  logic [1:0] la;
  logic [1:0] lb;
  logic [1:0] phase;

  modport master (
    output tick, ta, tb,
    input  la, lb, phase
  );

  modport slave (
    input  tick, ta, tb,
    output la, lb, phase
  );

endinterface

// File: rtl/dwell_counter.sv
// Saturating count of ticks spent in the current controller phase.
// A clear wins over a tick so a phase change always restarts at zero.
module dwell_counter #(
  parameter int MAX = 8,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         tick,
  output logic [W-1:0] count
);

  // Clear on phase change, otherwise count ticks and stick at MAX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick && (count != W'(MAX))) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic-light controller. Sequences AG -> AY -> BG -> BY with
// phase lengths measured in upstream ticks; greens are cut short when the
// own road is empty and forced off at the maximum when the other road waits.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN_TICKS = 3,
  parameter int MAX_GREEN_TICKS = 8,
  parameter int YELLOW_TICKS    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  traffic_light_ctrl_if.slave  bus
);

  localparam int          DW    = $clog2(MAX_GREEN_TICKS + 1);
  localparam logic [31:0] MIN_N = 32'(MIN_GREEN_TICKS);
  localparam logic [31:0] MAX_N = 32'(MAX_GREEN_TICKS);
  localparam logic [31:0] YEL_N = 32'(YELLOW_TICKS);

  state_t        state;
  state_t        state_next;
  logic [DW-1:0] dwell;
  logic          clear;
  logic [31:0]   n;
  logic [1:0]    la;
  logic [1:0]    lb;

  // Ticks already spent in this phase; cleared whenever the phase changes.
  dwell_counter #(
    .MAX (MAX_GREEN_TICKS),
    .W   (DW)
  ) u_dwell (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .tick  (bus.tick),
    .count (dwell)
  );

  // Phase register; reset forces road A green without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_AG;
    end else begin
      state <= state_next;
    end
  end

  // Next phase, evaluated only on tick cycles; n is the ordinal of this tick.
  always_comb begin
    state_next = state;
    n          = 32'(dwell) + 32'd1;
    if (bus.tick) begin
      case (state)
        S_AG: if (((n >= MIN_N) && !bus.ta) || ((n >= MAX_N) && bus.tb)) state_next = S_AY;
        S_AY: if (n == YEL_N) state_next = S_BG;
        S_BG: if (((n >= MIN_N) && !bus.tb) || ((n >= MAX_N) && bus.ta)) state_next = S_BY;
        S_BY: if (n == YEL_N) state_next = S_AG;
        default: state_next = S_AG;
      endcase
    end
    clear = (state_next != state);
  end

  // Moore decode of the phase register onto the two light heads.
  always_comb begin
    la = LIGHT_RED;
    lb = LIGHT_RED;
    case (state)
      S_AG: la = LIGHT_GREEN;
      S_AY: la = LIGHT_YELLOW;
      S_BG: lb = LIGHT_GREEN;
      S_BY: lb = LIGHT_YELLOW;
      default: begin
        la = LIGHT_RED;
        lb = LIGHT_RED;
      end
    endcase
  end

  assign bus.la    = la;
  assign bus.lb    = lb;
  assign bus.phase = state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl: a cycle model predicts lights,
// phase and dwell for every driven cycle into a scoreboard queue, and each
// scenario task adds its own directed checks on phase lengths.
module tb_traffic_light_ctrl;
  import traffic_pkg::*;

  localparam int MIN_G = 3;
  localparam int MAX_G = 8;
  localparam int YEL   = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  traffic_light_ctrl_if bus ();

  traffic_light_ctrl #(
    .MIN_GREEN_TICKS (MIN_G),
    .MAX_GREEN_TICKS (MAX_G),
    .YELLOW_TICKS    (YEL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0] la;
    logic [1:0] lb;
    logic [1:0] ph;
    int         dw;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_state = 0;
  int   m_cnt   = 0;

  function automatic logic [1:0] exp_la(int s);
    case (s)
      0:       return 2'b00;
      1:       return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [1:0] exp_lb(int s);
    case (s)
      2:       return 2'b00;
      3:       return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  function automatic void model_step(logic t, logic a, logic b);
    int n;
    bit go;
    go = 1'b0;
    if (t) begin
      n = m_cnt + 1;
      case (m_state)
        0:       go = ((n >= MIN_G) && !a) || ((n >= MAX_G) && b);
        2:       go = ((n >= MIN_G) && !b) || ((n >= MAX_G) && a);
        default: go = (n == YEL);
      endcase
      if (go) begin
        m_state = (m_state + 1) % 4;
        m_cnt   = 0;
      end else if (m_cnt < MAX_G) begin
        m_cnt = m_cnt + 1;
      end
    end
  endfunction

  task automatic cycle(input logic t, input logic a, input logic b);
    exp_t e;
    bus.tick = t;
    bus.ta   = a;
    bus.tb   = b;
    model_step(t, a, b);
    e = '{exp_la(m_state), exp_lb(m_state), 2'(m_state), m_cnt};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_tests++;
    if ({bus.la, bus.lb, bus.phase} !== {e.la, e.lb, e.ph}) begin
      n_fail++;
      $display("FAIL sb_outputs t=%0t: la/lb/phase got %b/%b/%0d expected %b/%b/%0d",
               $time, bus.la, bus.lb, bus.phase, e.la, e.lb, e.ph);
    end
    n_tests++;
    if (int'(dut.dwell) !== e.dw) begin
      n_fail++;
      $display("FAIL sb_dwell t=%0t: got %0d expected %0d", $time, dut.dwell, e.dw);
    end
  endtask

  task automatic apply_reset();
    bus.tick = 1'b0;
    bus.ta   = 1'b0;
    bus.tb   = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    m_state = 0;
    m_cnt   = 0;
    sb.delete();
  endtask

  // Counts ticks (one per 3 clocks) until the phase changes; bounded.
  task automatic count_ticks(input logic a, input logic b, output int n);
    logic [1:0] start;
    bit         done;
    start = bus.phase;
    done  = 1'b0;
    n     = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      cycle(1'b0, a, b);
      cycle(1'b0, a, b);
      cycle(1'b1, a, b);
      n++;
      if (bus.phase !== start) done = 1'b1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL count_ticks_timeout: phase stuck at %0d after %0d ticks", start, n);
    end
  endtask

  task automatic check_lights(input string name, input logic [1:0] la_e,
                              input logic [1:0] lb_e, input logic [1:0] ph_e);
    n_tests++;
    if ({bus.la, bus.lb, bus.phase} !== {la_e, lb_e, ph_e}) begin
      n_fail++;
      $display("FAIL %s: la/lb/phase got %b/%b/%0d expected %b/%b/%0d",
               name, bus.la, bus.lb, bus.phase, la_e, lb_e, ph_e);
    end
  endtask

  task automatic test_reset();
    bus.tick = 1'b0;
    bus.ta   = 1'b0;
    bus.tb   = 1'b0;
    reset    = 1'b1;
    #2;
    check_lights("reset_async", 2'b00, 2'b10, 2'd0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    m_state = 0;
    m_cnt   = 0;
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    check_lights("reset_hold", 2'b00, 2'b10, 2'd0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      if (bus.phase === 2'd1) break;
    end
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    check_lights("reach_yellow", 2'b01, 2'b10, 2'd1);
    reset = 1'b1;
    #2;
    check_lights("reset_mid_yellow", 2'b00, 2'b10, 2'd0);
    n_tests++;
    if (dut.dwell !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_yellow_dwell: got %0d expected 0", dut.dwell);
    end
    @(posedge clk);
    #1;
    reset   = 1'b0;
    m_state = 0;
    m_cnt   = 0;
  endtask

  task automatic test_no_traffic();
    int n;
    apply_reset();
    count_ticks(1'b0, 1'b0, n);
    n_tests++;
    if (n !== 3) begin
      n_fail++;
      $display("FAIL no_traffic_ag_len: got %0d ticks expected 3", n);
    end
    check_lights("no_traffic_ay", 2'b01, 2'b10, 2'd1);
    count_ticks(1'b0, 1'b0, n);
    n_tests++;
    if (n !== 2) begin
      n_fail++;
      $display("FAIL no_traffic_ay_len: got %0d ticks expected 2", n);
    end
    check_lights("no_traffic_bg", 2'b10, 2'b00, 2'd2);
  endtask

  task automatic test_hold_a();
    bit left;
    left = 1'b0;
    apply_reset();
    repeat (100) begin
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b0);
      if (bus.phase !== 2'd0) left = 1'b1;
    end
    n_tests++;
    if (left !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_a_phase: got left=%0d expected 0", left);
    end
    n_tests++;
    if (int'(dut.dwell) !== 8) begin
      n_fail++;
      $display("FAIL hold_a_dwell: got %0d expected 8", dut.dwell);
    end
  endtask

  task automatic test_both_waiting();
    int n;
    int exp_len[5];
    exp_len = '{8, 2, 8, 2, 8};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      count_ticks(1'b1, 1'b1, n);
      n_tests++;
      if (n !== exp_len[i]) begin
        n_fail++;
        $display("FAIL both_phase_len[%0d]: got %0d ticks expected %0d", i, n, exp_len[i]);
      end
    end
  endtask

  task automatic test_no_tick();
    int n;
    apply_reset();
    count_ticks(1'b0, 1'b0, n);
    count_ticks(1'b0, 1'b0, n);
    cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 200; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    check_lights("no_tick_frozen", 2'b10, 2'b00, 2'd2);
    n_tests++;
    if (int'(dut.dwell) !== 1) begin
      n_fail++;
      $display("FAIL no_tick_dwell: got %0d expected 1", dut.dwell);
    end
  endtask

  task automatic test_sensor_sample();
    apply_reset();
    repeat (5) begin
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b0);
    end
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    check_lights("sensor_off_tick_ignored", 2'b00, 2'b10, 2'd0);
    cycle(1'b1, 1'b0, 1'b0);
    check_lights("sensor_on_tick_exit", 2'b01, 2'b10, 2'd1);
  endtask

  task automatic test_every_clock();
    logic [1:0] exp_seq[6];
    exp_seq = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
    apply_reset();
    n_tests++;
    if (bus.la !== exp_seq[0]) begin
      n_fail++;
      $display("FAIL every_clock_la[0]: got %b expected %b", bus.la, exp_seq[0]);
    end
    for (int i = 1; i < 6; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      n_tests++;
      if (bus.la !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL every_clock_la[%0d]: got %b expected %b", i, bus.la, exp_seq[i]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_no_traffic();
    test_hold_a();
    test_both_waiting();
    test_no_tick();
    test_sensor_sample();
    test_every_clock();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
